// File: rtl/fsm_sync_pkg.sv
// fsm_sync shared types and defaults.
// State encoding plus default window and synchroniser depth.
package fsm_sync_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SHIFT    = 2'b01,
    CLR      = 2'b10,
    WAIT_LOW = 2'b11
  } state_t;

  localparam int SH_LEN_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/fsm_sync_if.sv
// RF strobe in, shift window controls out.
// master drives rfin; slave is the fsm_sync block.
interface fsm_sync_if;
  logic       rfin;
  logic       sh_en;
  logic       fsm_rst;
  logic [1:0] state;

  modport master (
    output rfin,
    input  sh_en,
    input  fsm_rst,
    input  state
  );

  modport slave (
    input  rfin,
    output sh_en,
    output fsm_rst,
    output state
  );
endinterface

// File: rtl/fsm_sync_edge_det.sv
// rfin synchroniser chain with rising-edge detect.
// rfin_s is the synchronised level; rise is one cycle wide.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rfin,
  output logic rfin_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   rfin_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain  <= '0;
      rfin_d <= 1'b0;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], rfin};
      rfin_d <= chain[SYNC_STAGES-1];
    end
  end

  assign rfin_s = chain[SYNC_STAGES-1];
  assign rise   = rfin_s & ~rfin_d;

endmodule

// File: rtl/fsm_sync.sv
// RF strobe synchroniser and shift-window control FSM.
// Opens an SH_LEN-cycle sh_en window, then a one-cycle fsm_rst.
module fsm_sync
  import fsm_sync_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int SH_LEN      = SH_LEN_DEF,
  parameter int CNT_W       = 8
) (
  input logic        clk,
  input logic        rst,
  fsm_sync_if.slave  bus
);

  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rfin_s;
  logic             rise;
  logic             sh_q;
  logic             clr_q;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .rfin   (bus.rfin),
    .rfin_s (rfin_s),
    .rise   (rise)
  );

  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    case (cur)
      IDLE: begin
        if (rise) begin
          nxt     = SHIFT;
          cnt_nxt = CNT_W'(SH_LEN - 1);
        end
      end
      SHIFT: begin
        if (cnt == '0) nxt = CLR;
        else cnt_nxt = cnt - CNT_W'(1);
      end
      CLR:      nxt = rfin_s ? WAIT_LOW : IDLE;
      WAIT_LOW: if (!rfin_s) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // Outputs come straight from flops so they cannot glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur   <= IDLE;
      cnt   <= '0;
      sh_q  <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      cur   <= nxt;
      cnt   <= cnt_nxt;
      sh_q  <= (nxt == SHIFT);
      clr_q <= (nxt == CLR);
    end
  end

  assign bus.sh_en   = sh_q;
  assign bus.fsm_rst = clr_q;
  assign bus.state   = cur;

endmodule

// File: tb/tb_fsm_sync.sv
// Directed bench for fsm_sync, SH_LEN=4, SYNC_STAGES=2.
// Outputs sampled 1 ns after the falling clock edge.
module tb_fsm_sync;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_ok;
  int   run;
  int   wins;
  int   pulses;
  logic prev_sh;
  int   w0;
  int   p0;

  fsm_sync_if bus ();

  fsm_sync #(
    .SYNC_STAGES (2),
    .SH_LEN      (4),
    .CNT_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0d want %0d at %0t",
                  tag, got, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic outs(input string tag,
                      input logic sh,
                      input logic fr,
                      input logic [1:0] st);
    chk({tag, ".sh_en"}, 32'(bus.sh_en), 32'(sh));
    chk({tag, ".fsm_rst"}, 32'(bus.fsm_rst), 32'(fr));
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
  endtask

  initial begin
    run     = 0;
    wins    = 0;
    pulses  = 0;
    prev_sh = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      run     = 0;
      prev_sh = 1'b0;
    end else begin
      chk("excl", 32'(bus.sh_en & bus.fsm_rst), 32'd0);
      if (bus.sh_en) run++;
      else if (prev_sh) begin
        chk("run_len", 32'(run), 32'd4);
        run = 0;
        wins++;
      end
      if (bus.fsm_rst) pulses++;
      prev_sh = bus.sh_en;
    end
  end

  initial begin
    n_chk    = 0;
    n_ok     = 0;
    rst      = 1'b0;
    bus.rfin = 1'b0;
    #30 bus.rfin = 1'b1;
    #40 outs("rst_a", 1'b0, 1'b0, 2'b00);
    bus.rfin = 1'b0;
    #60 bus.rfin = 1'b1;
    #40 outs("rst_b", 1'b0, 1'b0, 2'b00);
    bus.rfin = 1'b0;
    #10 rst = 1'b1;
    #25 bus.rfin = 1'b1;
    #90 bus.rfin = 1'b0;

    step(1); outs("p_300", 1'b0, 1'b0, 2'b00);
    step(1); outs("p_400", 1'b0, 1'b0, 2'b00);
    step(1); outs("p_500", 1'b1, 1'b0, 2'b01);
    step(1); outs("p_600", 1'b1, 1'b0, 2'b01);
    step(1); outs("p_700", 1'b1, 1'b0, 2'b01);
    step(1); outs("p_800", 1'b1, 1'b0, 2'b01);
    step(1); outs("p_900", 1'b0, 1'b1, 2'b10);
    step(1); outs("p_1000", 1'b0, 1'b0, 2'b00);
    chk("p_wins", 32'(wins), 32'd1);
    chk("p_pulses", 32'(pulses), 32'd1);

    w0 = wins;
    p0 = pulses;
    bus.rfin = 1'b1;
    step(20);
    outs("hold", 1'b0, 1'b0, 2'b11);
    chk("hold_wins", 32'(wins - w0), 32'd1);
    chk("hold_pulses", 32'(pulses - p0), 32'd1);
    bus.rfin = 1'b0;
    step(1); chk("hold_w1", 32'(bus.state), 32'd3);
    step(1); chk("hold_w2", 32'(bus.state), 32'd3);
    step(1); chk("hold_idle", 32'(bus.state), 32'd0);

    w0 = wins;
    bus.rfin = 1'b1;
    step(1); bus.rfin = 1'b0;
    chk("rt_l1", 32'(bus.state), 32'd0);
    step(1); chk("rt_l2", 32'(bus.state), 32'd0);
    step(1); outs("rt_on", 1'b1, 1'b0, 2'b01);
    step(1); bus.rfin = 1'b1;
    step(1); bus.rfin = 1'b0;
    step(1); outs("rt_sh4", 1'b1, 1'b0, 2'b01);
    step(1); outs("rt_clr", 1'b0, 1'b1, 2'b10);
    step(1); outs("rt_idle", 1'b0, 1'b0, 2'b00);
    step(5); outs("rt_quiet", 1'b0, 1'b0, 2'b00);
    chk("rt_wins", 32'(wins - w0), 32'd1);

    bus.rfin = 1'b1;
    step(1); bus.rfin = 1'b0;
    step(1); chk("re_l2", 32'(bus.state), 32'd0);
    step(1); outs("re_on", 1'b1, 1'b0, 2'b01);
    step(5); outs("re_done", 1'b0, 1'b0, 2'b00);

    p0 = pulses;
    bus.rfin = 1'b1;
    step(1); bus.rfin = 1'b0;
    step(2); outs("mr_on", 1'b1, 1'b0, 2'b01);
    #75 rst = 1'b0;
    #1 outs("mr_async", 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    #20 rst = 1'b1;
    step(3); outs("mr_after", 1'b0, 1'b0, 2'b00);
    chk("mr_pulses", 32'(pulses - p0), 32'd0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
